// File: rtl/ccr_unit.sv
`default_nettype none
// ============================================================================
// Module      : ccr_unit
// Description : Condition-code register (X N Z V C). Takes ALU flag updates
//               under a per-flag write mask, including sticky-Z for extended
//               arithmetic, and applies MOVE/AND/OR/EOR-to-CCR immediates.
//               Answers Bcc/Scc/DBcc/TRAPcc condition tests over a registered
//               valid/ack handshake, evaluated on forwarded next-state flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ccr_unit #(
    parameter logic [4:0] RESET_CCR = 5'b00000
) (
    input  logic       clk,
    input  logic       rst_n,
    // ALU flag update
    input  logic       upd_valid,
    input  logic [4:0] upd_xnzvc,
    input  logic [4:0] upd_mask,
    input  logic       upd_zsticky,
    // Immediate CCR operation
    input  logic       log_valid,
    input  logic [1:0] log_op,
    input  logic [4:0] log_data,
    // Condition test handshake
    input  logic       cc_req,
    input  logic [3:0] cc_sel,
    output logic       cc_ready,
    output logic       cc_valid,
    output logic       cc_true,
    input  logic       cc_ack,
    // Status
    output logic       upd_drop,
    output logic [4:0] ccr
);

    // Flag bit positions within the CCR byte
    localparam int c_BIT_X = 4;
    localparam int c_BIT_N = 3;
    localparam int c_BIT_Z = 2;
    localparam int c_BIT_V = 1;
    localparam int c_BIT_C = 0;

    // Immediate operation encodings
    localparam logic [1:0] c_LOG_MOVE = 2'b00;
    localparam logic [1:0] c_LOG_AND  = 2'b01;
    localparam logic [1:0] c_LOG_OR   = 2'b10;
    localparam logic [1:0] c_LOG_EOR  = 2'b11;

    // 68k condition encodings
    localparam logic [3:0] c_CC_T  = 4'h0;
    localparam logic [3:0] c_CC_F  = 4'h1;
    localparam logic [3:0] c_CC_HI = 4'h2;
    localparam logic [3:0] c_CC_LS = 4'h3;
    localparam logic [3:0] c_CC_CC = 4'h4;
    localparam logic [3:0] c_CC_CS = 4'h5;
    localparam logic [3:0] c_CC_NE = 4'h6;
    localparam logic [3:0] c_CC_EQ = 4'h7;
    localparam logic [3:0] c_CC_VC = 4'h8;
    localparam logic [3:0] c_CC_VS = 4'h9;
    localparam logic [3:0] c_CC_PL = 4'hA;
    localparam logic [3:0] c_CC_MI = 4'hB;
    localparam logic [3:0] c_CC_GE = 4'hC;
    localparam logic [3:0] c_CC_LT = 4'hD;
    localparam logic [3:0] c_CC_GT = 4'hE;
    localparam logic [3:0] c_CC_LE = 4'hF;

    logic [4:0] r_ccr;
    logic       r_cc_valid;
    logic       r_cc_true;
    logic       r_upd_drop;

    logic [4:0] w_log_ccr;
    logic [4:0] w_upd_ccr;
    logic [4:0] w_ccr_n;
    logic       w_collision;
    logic       w_cc_ready;
    logic       w_accept;
    logic       w_cond;
    logic       w_n;
    logic       w_z;
    logic       w_v;
    logic       w_c;
    logic       w_nv_eq;

    // Result of the immediate CCR operation against the current flags
    always_comb begin
        w_log_ccr = r_ccr;
        case (log_op)
            c_LOG_MOVE: w_log_ccr = log_data;
            c_LOG_AND:  w_log_ccr = r_ccr & log_data;
            c_LOG_OR:   w_log_ccr = r_ccr | log_data;
            c_LOG_EOR:  w_log_ccr = r_ccr ^ log_data;
            default:    w_log_ccr = r_ccr;
        endcase
    end

    // Per-flag masked ALU update; Z can only be cleared while sticky is set
    // so a multi-precision ADDX/SUBX chain reports zero only if every word was.
    for (genvar i = 0; i < 5; i++) begin : g_upd_bit
        if (i == c_BIT_Z) begin : g_sticky_z
            assign w_upd_ccr[i] = !upd_mask[i] ? r_ccr[i] :
                                  upd_zsticky  ? (r_ccr[i] & upd_xnzvc[i]) :
                                                 upd_xnzvc[i];
        end else begin : g_plain
            assign w_upd_ccr[i] = upd_mask[i] ? upd_xnzvc[i] : r_ccr[i];
        end
    end

    // Next-state selection: immediate op outranks the ALU update
    always_comb begin
        w_ccr_n = r_ccr;
        if (log_valid) begin
            w_ccr_n = w_log_ccr;
        end else if (upd_valid) begin
            w_ccr_n = w_upd_ccr;
        end
    end

    assign w_collision = log_valid & upd_valid;

    // Conditions look at forwarded flags so a test alongside an update sees it.
    // X is deliberately absent from every condition.
    assign w_n     = w_ccr_n[c_BIT_N];
    assign w_z     = w_ccr_n[c_BIT_Z];
    assign w_v     = w_ccr_n[c_BIT_V];
    assign w_c     = w_ccr_n[c_BIT_C];
    assign w_nv_eq = w_n ~^ w_v;

    // Condition table lookup
    always_comb begin
        w_cond = 1'b0;
        case (cc_sel)
            c_CC_T:  w_cond = 1'b1;
            c_CC_F:  w_cond = 1'b0;
            c_CC_HI: w_cond = !w_c & !w_z;
            c_CC_LS: w_cond = w_c | w_z;
            c_CC_CC: w_cond = !w_c;
            c_CC_CS: w_cond = w_c;
            c_CC_NE: w_cond = !w_z;
            c_CC_EQ: w_cond = w_z;
            c_CC_VC: w_cond = !w_v;
            c_CC_VS: w_cond = w_v;
            c_CC_PL: w_cond = !w_n;
            c_CC_MI: w_cond = w_n;
            c_CC_GE: w_cond = w_nv_eq;
            c_CC_LT: w_cond = !w_nv_eq;
            c_CC_GT: w_cond = !w_z & w_nv_eq;
            c_CC_LE: w_cond = w_z | !w_nv_eq;
            default: w_cond = 1'b0;
        endcase
    end

    // Ready whenever the result slot is empty or being drained this cycle
    assign w_cc_ready = !r_cc_valid | cc_ack;
    assign w_accept   = cc_req & w_cc_ready;

    // CCR storage and collision indicator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ccr      <= RESET_CCR;
            r_upd_drop <= 1'b0;
        end else begin
            r_ccr      <= w_ccr_n;
            r_upd_drop <= w_collision;
        end
    end

    // Result slot: a new accept overwrites, an ack alone empties it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc_valid <= 1'b0;
            r_cc_true  <= 1'b0;
        end else if (w_accept) begin
            r_cc_valid <= 1'b1;
            r_cc_true  <= w_cond;
        end else if (cc_ack) begin
            r_cc_valid <= 1'b0;
        end
    end

    assign ccr      = r_ccr;
    assign cc_valid = r_cc_valid;
    assign cc_true  = r_cc_true;
    assign cc_ready = w_cc_ready;
    assign upd_drop = r_upd_drop;

endmodule
`default_nettype wire

// File: tb/tb_ccr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccr_unit
// Description : Self-checking bench for ccr_unit. Directed scenarios followed
//               by a randomized run, all compared against a flag-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccr_unit;

    localparam logic [4:0] c_RESET_CCR = 5'b10101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       upd_valid = 1'b0;
    logic [4:0] upd_xnzvc = '0;
    logic [4:0] upd_mask = '0;
    logic       upd_zsticky = 1'b0;
    logic       log_valid = 1'b0;
    logic [1:0] log_op = '0;
    logic [4:0] log_data = '0;
    logic       cc_req = 1'b0;
    logic [3:0] cc_sel = '0;
    logic       cc_ready;
    logic       cc_valid;
    logic       cc_true;
    logic       cc_ack = 1'b0;
    logic       upd_drop;
    logic [4:0] ccr;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [4:0] m_ccr;
    bit         m_valid;
    bit         m_true;
    bit         m_drop;

    ccr_unit #(.RESET_CCR(c_RESET_CCR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd_valid   (upd_valid),
        .upd_xnzvc   (upd_xnzvc),
        .upd_mask    (upd_mask),
        .upd_zsticky (upd_zsticky),
        .log_valid   (log_valid),
        .log_op      (log_op),
        .log_data    (log_data),
        .cc_req      (cc_req),
        .cc_sel      (cc_sel),
        .cc_ready    (cc_ready),
        .cc_valid    (cc_valid),
        .cc_true     (cc_true),
        .cc_ack      (cc_ack),
        .upd_drop    (upd_drop),
        .ccr         (ccr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Even codes are the "positive" test, the following odd code is its negation
    function automatic bit cond_eval(input logic [3:0] sel, input logic [4:0] f);
        bit n, z, v, c, base;
        n = f[3]; z = f[2]; v = f[1]; c = f[0];
        case (sel[3:1])
            3'd0: base = 1'b1;                 // T
            3'd1: base = (c == 0) && (z == 0); // HI
            3'd2: base = (c == 0);             // CC
            3'd3: base = (z == 0);             // NE
            3'd4: base = (v == 0);             // VC
            3'd5: base = (n == 0);             // PL
            3'd6: base = (n == v);             // GE
            default: base = (z == 0) && (n == v); // GT
        endcase
        return sel[0] ? !base : base;
    endfunction

    function automatic logic [4:0] model_next();
        logic [4:0] r;
        r = m_ccr;
        if (log_valid) begin
            case (log_op)
                2'd0: r = log_data;
                2'd1: r = m_ccr & log_data;
                2'd2: r = m_ccr | log_data;
                default: r = m_ccr ^ log_data;
            endcase
        end else if (upd_valid) begin
            r = (m_ccr & ~upd_mask) | (upd_xnzvc & upd_mask);
            if (upd_zsticky && upd_mask[2]) r[2] = m_ccr[2] & upd_xnzvc[2];
        end
        return r;
    endfunction

    task automatic set_in(input bit lv, input logic [1:0] op, input logic [4:0] ld,
                          input bit uv, input logic [4:0] ux, input logic [4:0] um,
                          input bit zs, input bit rq, input logic [3:0] sel, input bit ack);
        log_valid = lv; log_op = op; log_data = ld;
        upd_valid = uv; upd_xnzvc = ux; upd_mask = um; upd_zsticky = zs;
        cc_req = rq; cc_sel = sel; cc_ack = ack;
    endtask

    // One clock: check ready, advance the model alongside the DUT, compare outputs
    task automatic cycle();
        logic [4:0] nx;
        bit ready_e, acc, cond;
        #1;
        ready_e = !m_valid || cc_ack;
        check("cc_ready", {4'b0, cc_ready}, {4'b0, ready_e});
        nx   = model_next();
        acc  = cc_req && ready_e;
        cond = cond_eval(cc_sel, nx);
        @(posedge clk);
        #1;
        m_drop = log_valid && upd_valid;
        m_ccr  = nx;
        if (acc) begin
            m_valid = 1'b1;
            m_true  = cond;
        end else if (cc_ack) begin
            m_valid = 1'b0;
        end
        check("ccr", ccr, m_ccr);
        check("upd_drop", {4'b0, upd_drop}, {4'b0, m_drop});
        check("cc_valid", {4'b0, cc_valid}, {4'b0, m_valid});
        check("cc_true", {4'b0, cc_true}, {4'b0, m_true});
    endtask

    // Asynchronous assertion checked with no clock edge, release away from the edge
    task automatic do_reset();
        set_in(0, 2'd0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 4'd0, 0);
        rst_n = 1'b0;
        #1;
        check("rst_ccr", ccr, c_RESET_CCR);
        check("rst_cc_valid", {4'b0, cc_valid}, 5'd0);
        check("rst_cc_true", {4'b0, cc_true}, 5'd0);
        check("rst_upd_drop", {4'b0, upd_drop}, 5'd0);
        check("rst_cc_ready", {4'b0, cc_ready}, 5'd1);
        m_ccr = c_RESET_CCR; m_valid = 0; m_true = 0; m_drop = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();

        // Masked update then EOR immediate
        set_in(1, 2'd0, 5'b00000, 0, 5'd0, 5'd0, 0, 0, 4'd0, 0); cycle();
        set_in(0, 2'd0, 5'd0, 1, 5'b11111, 5'b01110, 0, 0, 4'd0, 0); cycle();
        check("mask_upd", ccr, 5'b01110);
        set_in(1, 2'd3, 5'b11111, 0, 5'd0, 5'd0, 0, 0, 4'd0, 0); cycle();
        check("eor_imm", ccr, 5'b10001);

        // Sticky Z: stays set, clears, then cannot be set again
        set_in(1, 2'd0, 5'b00100, 0, 5'd0, 5'd0, 0, 0, 4'd0, 0); cycle();
        set_in(0, 2'd0, 5'd0, 1, 5'b00100, 5'b11111, 1, 0, 4'd0, 0); cycle();
        check("sticky_hold", ccr, 5'b00100);
        set_in(0, 2'd0, 5'd0, 1, 5'b00000, 5'b11111, 1, 0, 4'd0, 0); cycle();
        check("sticky_clr", ccr, 5'b00000);
        set_in(0, 2'd0, 5'd0, 1, 5'b00100, 5'b11111, 1, 0, 4'd0, 0); cycle();
        check("sticky_noset", ccr, 5'b00000);

        // Forwarding: EQ tested in the same cycle as the update that sets Z
        set_in(0, 2'd0, 5'd0, 1, 5'b00100, 5'b11111, 0, 1, 4'h7, 0); cycle();
        check("fwd_valid", {4'b0, cc_valid}, 5'd1);
        check("fwd_true", {4'b0, cc_true}, 5'd1);
        check("fwd_ccr", ccr, 5'b00100);

        // Collision: immediate wins, drop pulses for exactly one cycle
        set_in(1, 2'd0, 5'b01010, 1, 5'b11111, 5'b11111, 0, 0, 4'd0, 0); cycle();
        check("coll_ccr", ccr, 5'b01010);
        check("coll_drop", {4'b0, upd_drop}, 5'd1);
        set_in(0, 2'd0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 4'd0, 0); cycle();
        check("coll_drop_end", {4'b0, upd_drop}, 5'd0);

        // Held request without ack is not accepted; pending result unchanged
        set_in(0, 2'd0, 5'd0, 0, 5'd0, 5'd0, 0, 1, 4'h1, 0); cycle();
        cycle();
        check("hold_true", {4'b0, cc_true}, 5'd1);

        // Signed-compare corner cases
        set_in(1, 2'd0, 5'b01010, 0, 5'd0, 5'd0, 0, 1, 4'hE, 1); cycle();
        check("gt_nv", {4'b0, cc_true}, 5'd1);
        set_in(1, 2'd0, 5'b01000, 0, 5'd0, 5'd0, 0, 1, 4'hF, 1); cycle();
        check("le_n", {4'b0, cc_true}, 5'd1);

        // Full sweep, one test per cycle with ack held high
        for (int p = 0; p < 16; p++) begin
            for (int s = 0; s < 16; s++) begin
                set_in(1, 2'd0, {1'($urandom_range(0, 1)), 4'(p)}, 0, 5'd0, 5'd0, 0,
                       1, 4'(s), 1);
                cycle();
            end
        end

        // Reset while a result is pending
        set_in(0, 2'd0, 5'd0, 0, 5'd0, 5'd0, 0, 1, 4'h0, 0); cycle();
        do_reset();
        cycle();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            set_in(($urandom_range(0, 3) == 0), 2'($urandom), 5'($urandom),
                   ($urandom_range(0, 1) == 1), 5'($urandom), 5'($urandom),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) < 3),
                   4'($urandom), ($urandom_range(0, 1) == 1));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ccr_unit.md
# ccr_unit

Condition-code register for the execution core. It holds the XNZVC flag byte and takes flag updates from the ALU's `out_xnzvc` under a per-instruction write mask, including the sticky-Z rule for extended arithmetic. It also applies MOVE/AND/OR/EOR-to-CCR immediate operations. It answers condition-test requests (Bcc/Scc/DBcc/TRAPcc) from the sequencer over a registered valid/ack handshake.

## Interface
Parameters:
- `RESET_CCR`, 5'b00000: CCR value loaded on reset. Bit order is X[4] N[3] Z[2] V[1] C[0].

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `upd_valid`  in  1  ALU flag update strobe, one cycle per instruction.
- `upd_xnzvc`  in  5  flags from the ALU.
- `upd_mask`  in  5  per-flag write enable; 1 = write that bit.
- `upd_zsticky`  in  1  Z only clears, never sets (ADDX/SUBX/NEGX).
- `log_valid`  in  1  immediate CCR operation strobe.
- `log_op`  in  2  00 MOVE, 01 AND, 10 OR, 11 EOR.
- `log_data`  in  5  immediate operand.
- `cc_req`  in  1  condition-test request.
- `cc_sel`  in  4  condition code (68k encoding).
- `cc_ready`  out  1  request accepted this cycle when high.
- `cc_valid`  out  1  result pending.
- `cc_true`  out  1  condition result; meaningful only while `cc_valid` is high.
- `cc_ack`  in  1  consumer takes the result.
- `upd_drop`  out  1  one-cycle pulse: an update was discarded due to a collision.
- `ccr`  out  5  current CCR contents (registered).

## Operation
- Next-state `ccr_n` is computed from priority-ordered sources each cycle:
  - `log_valid` is highest. MOVE gives `log_data`. AND gives `ccr & log_data`. OR gives `ccr | log_data`. EOR gives `ccr ^ log_data`.
  - Otherwise `upd_valid` applies. Each bit i with `upd_mask[i]` = 1 takes `upd_xnzvc[i]`, except Z when `upd_zsticky` = 1, which takes `ccr[2] & upd_xnzvc[2]`. Bits with mask 0 are held.
  - If neither strobe is high, `ccr_n = ccr`.
- Collision: `log_valid` and `upd_valid` high in the same cycle.
  - The log op is applied and the update is discarded entirely.
  - `upd_drop` = 1 on the following cycle.
- Condition evaluation uses `ccr_n` (forwarded), not `ccr`. A test issued in the same cycle as an update therefore sees the updated flags.
- Condition table, where N,Z,V,C refer to `ccr_n`:
  - 0 T = 1; 1 F = 0
  - 2 HI = !C&!Z; 3 LS = C|Z
  - 4 CC = !C; 5 CS = C
  - 6 NE = !Z; 7 EQ = Z
  - 8 VC = !V; 9 VS = V
  - A PL = !N; B MI = N
  - C GE = N~^V; D LT = N^V
  - E GT = !Z&(N~^V); F LE = Z|(N^V)
  - X never participates in any condition.
- Handshake:
  - `cc_ready = !cc_valid | cc_ack` (combinational).
  - A request is accepted when `cc_req & cc_ready`.
  - Accept: `cc_valid` ← 1 and `cc_true` ← evaluated value at the next edge.
  - `cc_ack` without a new accept: `cc_valid` ← 0; `cc_true` holds its last value.
  - `cc_req` while not ready is ignored (not queued). The requester must hold it.
  - `cc_ack` while `cc_valid` = 0 has no effect.

## Timing
- Reset (async assert, sync-released by the top level) forces:
  - `ccr` = `RESET_CCR`
  - `cc_valid` = 0, `cc_true` = 0, `upd_drop` = 0
  - `cc_ready` = 1 (combinational result of `cc_valid` = 0)
- Flag write latency is 1 cycle: strobe in cycle N, `ccr` visible in cycle N+1.
- Condition latency is 1 cycle: accept in cycle N, `cc_valid`/`cc_true` in cycle N+1.
- Back-to-back tests are supported: with `cc_ack` and `cc_req` both high while `cc_valid` = 1, the new result replaces the old one with no bubble. Full throughput is one test per cycle.
- Reset mid-handshake discards the pending result. No ack is required after reset.

## Test plan
- Reset: assert `rst_n` = 0 with `RESET_CCR` = 5'b10101 -> `ccr` = 10101, `cc_valid` = 0, `cc_ready` = 1 with no clock edge.
- Masked update: `ccr` = 00000, upd `xnzvc` = 11111, mask = 01110 -> `ccr` = 01110 next cycle. Then EOR `log_data` 11111 -> 10001.
- Sticky Z: `ccr` = 00100, upd `xnzvc` = 00100, mask = 11111, zsticky = 1 -> Z stays 1. Next upd `xnzvc` = 00000 -> Z = 0. Next upd `xnzvc` = 00100 -> Z stays 0.
- Forwarding: same cycle as upd (mask 11111, `xnzvc` 00100), `cc_req` with `cc_sel` = 7 (EQ) -> next cycle `cc_valid` = 1, `cc_true` = 1, `ccr` = 00100.
- Collision: `log_valid` MOVE 01010 together with upd `xnzvc` 11111 mask 11111 -> `ccr` = 01010, `upd_drop` pulses for 1 cycle.
- Handshake and condition sweep: hold `cc_req` without ack while `cc_valid` = 1 -> `cc_ready` = 0 and the result is unchanged. Then sweep all 16 `cc_sel` values over all 16 NZVC patterns with ack tied high -> one result per cycle, matching the table (GT with N=1,V=1,Z=0 -> 1; LE with N=1,V=0 -> 1).
